// File: rtl/hazard_scoreboard_if.sv
// Hazard/scoreboard bus: ID/EX pipeline info in, stall/flush/divide status out.
// master drives the pipeline side; slave is the scoreboard.
interface hazard_scoreboard_if;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        rs1_used;
  logic        rs2_used;
  logic [4:0]  rd_id;
  logic        reg_file_wr_id;
  logic        div_id;
  logic [4:0]  rd_ex;
  logic        mem_read_ex;
  logic        div_issue_ex;
  logic        branch_taken_ex;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        flush_ex;
  logic        div_busy;
  logic [4:0]  pending_rd;
  logic        div_wb_valid;
  logic [31:0] stall_count;

  modport master (
    output rs1_id, rs2_id, rs1_used, rs2_used, rd_id, reg_file_wr_id, div_id,
           rd_ex, mem_read_ex, div_issue_ex, branch_taken_ex,
    input  stall_if, stall_id, flush_id, flush_ex, div_busy, pending_rd,
           div_wb_valid, stall_count
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used, rs2_used, rd_id, reg_file_wr_id, div_id,
           rd_ex, mem_read_ex, div_issue_ex, branch_taken_ex,
    output stall_if, stall_id, flush_id, flush_ex, div_busy, pending_rd,
           div_wb_valid, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use and multi-cycle divide scoreboard driving
// stall/flush controls, plus a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int DIV_LATENCY = 32
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_pending_rd;
  logic             r_div_busy;
  logic             r_div_wb;
  logic [31:0]      r_stall_count;

  logic w_load_use;
  logic w_raw_div;
  logic w_waw_div;
  logic w_struct_div;
  logic w_hazard;
  logic w_branch;
  logic w_stall;

  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // x0 is hardwired, so a zero destination can never be a dependency.
  function automatic logic f_src_match(input logic [4:0] rs, input logic used,
                                       input logic [4:0] rd);
    return used && (rd != 5'd0) && (rs == rd);
  endfunction

  assign w_load_use   = bus.mem_read_ex &&
                        (f_src_match(bus.rs1_id, bus.rs1_used, bus.rd_ex) ||
                         f_src_match(bus.rs2_id, bus.rs2_used, bus.rd_ex));
  assign w_raw_div    = r_div_busy &&
                        (f_src_match(bus.rs1_id, bus.rs1_used, r_pending_rd) ||
                         f_src_match(bus.rs2_id, bus.rs2_used, r_pending_rd));
  assign w_waw_div    = r_div_busy && bus.reg_file_wr_id &&
                        (bus.rd_id != 5'd0) && (bus.rd_id == r_pending_rd);
  // A second divide in ID must wait for the divider to drain, like a RAW stall.
  assign w_struct_div = r_div_busy && bus.div_id && bus.reg_file_wr_id;
  assign w_hazard     = w_load_use | w_raw_div | w_waw_div | w_struct_div;

  // Controls are forced low while reset is held; a taken branch overrides stalls.
  assign w_branch = rst_n & bus.branch_taken_ex;
  assign w_stall  = rst_n & w_hazard & ~bus.branch_taken_ex;

  assign bus.stall_if     = w_stall;
  assign bus.stall_id     = w_stall;
  assign bus.flush_id     = w_branch;
  assign bus.flush_ex     = w_stall | w_branch;
  assign bus.div_busy     = r_div_busy;
  assign bus.pending_rd   = r_pending_rd;
  assign bus.div_wb_valid = r_div_wb;
  assign bus.stall_count  = r_stall_count;

  // The divide in EX is already older than any flush this unit raises, so
  // div_issue_ex is taken as-is; a branch never cancels an in-flight divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pending_rd  <= '0;
      r_div_busy    <= 1'b0;
      r_div_wb      <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (w_stall) r_stall_count <= f_sat_inc(r_stall_count);
      r_div_wb <= 1'b0;
      case (r_state)
        S_IDLE, S_WB: begin
          if (bus.div_issue_ex) begin
            r_pending_rd <= bus.rd_ex;
            r_cnt        <= CNT_INIT;
            r_div_busy   <= 1'b1;
            if (DIV_LATENCY == 1) begin
              r_state  <= S_WB;
              r_div_wb <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end else begin
            r_state    <= S_IDLE;
            r_div_busy <= 1'b0;
          end
        end
        S_BUSY: begin
          // Issue here is illegal and ignored; WB lands DIV_LATENCY cycles after issue.
          if (r_cnt <= CNT_W'(1)) begin
            r_state  <= S_WB;
            r_cnt    <= '0;
            r_div_wb <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_div_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: table of single-cycle hazard vectors
// followed by hand-written divide, branch and reset sequences.
module tb_hazard_scoreboard;
  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;
  logic [31:0] exp_cnt;

  hazard_scoreboard_if bus ();

  hazard_scoreboard #(.DIV_LATENCY(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       divid;
    logic [4:0] rd_ex;
    logic       mr;
    logic       br;
    logic       e_stall;
    logic       e_fid;
    logic       e_fex;
    string      name;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic wr,
                          input logic divid);
    bus.rs1_id = rs1;  bus.rs2_id = rs2;
    bus.rs1_used = u1; bus.rs2_used = u2;
    bus.rd_id = rd;    bus.reg_file_wr_id = wr;
    bus.div_id = divid;
  endtask

  task automatic drive_ex(input logic [4:0] rd_ex, input logic mr, input logic issue,
                          input logic br);
    bus.rd_ex = rd_ex; bus.mem_read_ex = mr;
    bus.div_issue_ex = issue; bus.branch_taken_ex = br;
  endtask

  // Checks one sampled cycle and advances the stall-count model.
  task automatic cycle_chk(input string tag, input int k, input logic es, input logic efid,
                           input logic efex, input logic ebusy, input logic ewb);
    check($sformatf("%s[%0d] stall_if", tag, k), {31'd0, bus.stall_if}, {31'd0, es});
    check($sformatf("%s[%0d] stall_id", tag, k), {31'd0, bus.stall_id}, {31'd0, es});
    check($sformatf("%s[%0d] flush_id", tag, k), {31'd0, bus.flush_id}, {31'd0, efid});
    check($sformatf("%s[%0d] flush_ex", tag, k), {31'd0, bus.flush_ex}, {31'd0, efex});
    check($sformatf("%s[%0d] div_busy", tag, k), {31'd0, bus.div_busy}, {31'd0, ebusy});
    check($sformatf("%s[%0d] div_wb_valid", tag, k), {31'd0, bus.div_wb_valid}, {31'd0, ewb});
    check($sformatf("%s[%0d] stall_count", tag, k), bus.stall_count, exp_cnt);
    if (es) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    exp_cnt = 32'd0;
    //           rs1    rs2    u1    u2    rd     wr    div   rd_ex  mr    br    st    fid   fex
    vecs[0] = '{5'd5, 5'd1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "lu_rs1"};
    vecs[1] = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "lu_rs2"};
    vecs[2] = '{5'd5, 5'd1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lu_unused"};
    vecs[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lu_x0"};
    vecs[4] = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "no_load"};
    vecs[5] = '{5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "lu_nomatch"};
    vecs[6] = '{5'd5, 5'd1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "lu_branch"};
    vecs[7] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "branch"};
    vecs[8] = '{5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "div_idle"};
    vecs[9] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "quiet"};

    // Reset held with a live load-use hazard and branch: everything must read 0.
    rst_n = 1'b0;
    drive_id(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    drive_ex(5'd5, 1'b1, 1'b0, 1'b1);
    #12;
    cycle_chk("rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst pending_rd", {27'd0, bus.pending_rd}, 32'd0);
    @(negedge clk);
    drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_id(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].wr,
               vecs[i].divid);
      drive_ex(vecs[i].rd_ex, vecs[i].mr, 1'b0, vecs[i].br);
      #1;
      cycle_chk(vecs[i].name, i, vecs[i].e_stall, vecs[i].e_fid, vecs[i].e_fex, 1'b0, 1'b0);
    end

    // A: DIV x7 then ID reads x7; stall 32 cycles including WB.
    @(negedge clk);
    drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_ex(5'd7, 1'b0, 1'b1, 1'b0);
    #1;
    cycle_chk("A", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      drive_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
      drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      cycle_chk("A", k, k <= 32, 1'b0, k <= 32, k <= 32, k == 32);
      if (k <= 32) check($sformatf("A[%0d] pending_rd", k), {27'd0, bus.pending_rd}, 32'd7);
    end

    // B: independent add proceeds, then WAW on x7 stalls through WB.
    @(negedge clk);
    drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_ex(5'd7, 1'b0, 1'b1, 1'b0);
    #1;
    cycle_chk("B", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k <= 3) drive_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      else        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
      drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      cycle_chk("B", k, (k >= 4) && (k <= 32), 1'b0, (k >= 4) && (k <= 32), k <= 32, k == 32);
    end

    // C: RAW stall, branch override, structural stall, issue in WB, ignored issue in BUSY.
    @(negedge clk);
    drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_ex(5'd9, 1'b0, 1'b1, 1'b0);
    #1;
    cycle_chk("C", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k <= 6)       drive_id(5'd9, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
      else if (k <= 31) drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1);
      else              drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      if (k == 32)      drive_ex(5'd11, 1'b0, 1'b1, 1'b0);
      else              drive_ex(5'd0, 1'b0, 1'b0, k == 6);
      #1;
      cycle_chk("C", k, (k != 6) && (k <= 31), k == 6, k <= 31, 1'b1, k == 32);
      check($sformatf("C[%0d] pending_rd", k), {27'd0, bus.pending_rd}, 32'd9);
    end
    for (int j = 1; j <= 33; j++) begin
      @(negedge clk);
      drive_id(5'd11, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
      if (j == 8) drive_ex(5'd12, 1'b0, 1'b1, 1'b0);
      else        drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      cycle_chk("C2", j, j <= 32, 1'b0, j <= 32, j <= 32, j == 32);
      if (j <= 32) check($sformatf("C2[%0d] pending_rd", j), {27'd0, bus.pending_rd}, 32'd11);
    end

    // E: DIV x0 in flight never stalls a reader/writer of x0.
    @(negedge clk);
    drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_ex(5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    cycle_chk("E", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      drive_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
      drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      cycle_chk("E", k, 1'b0, 1'b0, 1'b0, k <= 32, k == 32);
    end

    // D: reset at divide cycle 10 abandons the divide.
    @(negedge clk);
    drive_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive_ex(5'd7, 1'b0, 1'b1, 1'b0);
    #1;
    cycle_chk("D", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      drive_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
      drive_ex(5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      cycle_chk("D", k, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    #1;
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    #1;
    cycle_chk("Drst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("Drst pending_rd", {27'd0, bus.pending_rd}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      cycle_chk("Dpost", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
